// File: rtl/imm_decode_stage.sv
// Purpose: registered immediate decode for RV32/RV64 instruction words, with PC-relative target and illegal flag.
// Latency: 1 cycle from the capture edge to out_valid; 1 instruction per cycle when out_ready stays high.
// Backpressure: in_ready = !rst && (!out_valid || out_ready); the held entry is frozen while out_ready is low.
module imm_decode_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [XLEN-1:0]  out_target,
    output logic [XLEN-1:0]  out_pc,
    output logic             out_illegal,
    output logic [CNT_W-1:0] cnt_accepted,
    output logic [CNT_W-1:0] cnt_illegal
);

    // Only RV32 and RV64 datapaths are meaningful for this decoder.
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_decode_stage: XLEN must be 32 or 64");
    end

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6
    } fmt_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    fmt_e            fmt;
    logic            illegal;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    logic            capture;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];

    // Pick the immediate format from the opcode; anything unrecognised
    // (including words whose low two bits are not 11) is flagged illegal.
    always_comb begin
        fmt     = FMT_NONE;
        illegal = 1'b0;
        case (opcode)
            7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111: fmt = FMT_I;
            7'b0100011: fmt = FMT_S;
            7'b1100011: fmt = FMT_B;
            7'b0110111, 7'b0010111: fmt = FMT_U;
            7'b1101111: fmt = FMT_J;
            7'b0110011: fmt = FMT_NONE;
            7'b1110011: begin
                if (funct3 == 3'b000) begin
                    fmt = FMT_NONE;
                end else if (funct3[2]) begin
                    fmt = FMT_Z;
                end else begin
                    fmt = FMT_I;
                end
            end
            7'b0011011: begin
                // OP-IMM-32 only exists on a 64-bit datapath.
                if (XLEN == 64) begin
                    fmt = FMT_I;
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
    end

    // Assemble a 32-bit sign-correct immediate; Z is zero-extended because its bit 31 is 0.
    always_comb begin
        imm32 = 32'd0;
        case (fmt)
            FMT_I: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            FMT_S: imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            FMT_B: imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                            in_instr[30:25], in_instr[11:8], 1'b0};
            FMT_U: imm32 = {in_instr[31:12], 12'd0};
            FMT_J: imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                            in_instr[20], in_instr[30:21], 1'b0};
            FMT_Z: imm32 = {27'd0, in_instr[19:15]};
            default: imm32 = 32'd0;
        endcase
    end

    // Widen to XLEN by replicating bit 31, then form the wrapping PC-relative target.
    assign imm    = XLEN'($signed(imm32));
    assign target = in_pc + imm;

    assign in_ready = !rst && (!out_valid || out_ready);
    assign capture  = in_valid && in_ready && !flush;

    // Output register: reset clears, flush drops the entry, capture loads all fields together.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_imm     <= '0;
            out_fmt     <= 3'd0;
            out_target  <= '0;
            out_pc      <= '0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid   <= 1'b1;
            out_imm     <= imm;
            out_fmt     <= fmt;
            out_target  <= target;
            out_pc      <= in_pc;
            out_illegal <= illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Saturating statistics; flush suppresses capture so it never counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_accepted <= '0;
            cnt_illegal  <= '0;
        end else if (capture) begin
            if (cnt_accepted != CNT_MAX) begin
                cnt_accepted <= cnt_accepted + 1'b1;
            end
            if (illegal && cnt_illegal != CNT_MAX) begin
                cnt_illegal <= cnt_illegal + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench driving three instances (RV32, RV64, RV32 with 3-bit counters) from shared stimulus.
module tb_imm_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [63:0] pc;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_out_illegal;
    logic [31:0] a_out_imm, a_out_target, a_out_pc;
    logic [2:0]  a_out_fmt;
    logic [15:0] a_cnt_acc, a_cnt_ill;

    logic        b_in_ready, b_out_valid, b_out_illegal;
    logic [63:0] b_out_imm, b_out_target, b_out_pc;
    logic [2:0]  b_out_fmt;
    logic [15:0] b_cnt_acc, b_cnt_ill;

    logic        s_in_ready, s_out_valid, s_out_illegal;
    logic [31:0] s_out_imm, s_out_target, s_out_pc;
    logic [2:0]  s_out_fmt;
    logic [2:0]  s_cnt_acc, s_cnt_ill;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(32), .CNT_W(16)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instr(in_instr), .in_pc(pc[31:0]), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_imm(a_out_imm), .out_fmt(a_out_fmt), .out_target(a_out_target), .out_pc(a_out_pc),
        .out_illegal(a_out_illegal), .cnt_accepted(a_cnt_acc), .cnt_illegal(a_cnt_ill));

    imm_decode_stage #(.XLEN(64), .CNT_W(16)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instr(in_instr), .in_pc(pc), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_imm(b_out_imm), .out_fmt(b_out_fmt), .out_target(b_out_target), .out_pc(b_out_pc),
        .out_illegal(b_out_illegal), .cnt_accepted(b_cnt_acc), .cnt_illegal(b_cnt_ill));

    imm_decode_stage #(.XLEN(32), .CNT_W(3)) dutsat (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_instr(in_instr), .in_pc(pc[31:0]), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_imm(s_out_imm), .out_fmt(s_out_fmt), .out_target(s_out_target), .out_pc(s_out_pc),
        .out_illegal(s_out_illegal), .cnt_accepted(s_cnt_acc), .cnt_illegal(s_cnt_ill));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = 32'h0; pc = 64'h0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        in_instr = 32'h00500093; pc = 64'h40;
        tick(); tick();
        tests++; if (a_in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b exp 0", a_in_ready); end
        tests++; if (a_out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", a_out_valid); end
        tests++; if ({a_out_imm, a_out_target, a_out_pc, a_out_fmt, a_out_illegal} !== 100'd0) begin
            fails++; $display("FAIL reset_data32 got imm %0h tgt %0h pc %0h fmt %0d ill %b exp all 0",
                              a_out_imm, a_out_target, a_out_pc, a_out_fmt, a_out_illegal); end
        tests++; if ({b_out_imm, b_out_target, b_out_pc} !== 192'd0 || b_in_ready !== 1'b0) begin
            fails++; $display("FAIL reset_data64 got imm %0h tgt %0h pc %0h rdy %b exp all 0",
                              b_out_imm, b_out_target, b_out_pc, b_in_ready); end
        tests++; if (a_cnt_acc !== 16'd0 || a_cnt_ill !== 16'd0) begin
            fails++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", a_cnt_acc, a_cnt_ill); end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        tests++; if (a_in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready got %b exp 1", a_in_ready); end
    endtask

    task automatic test_branch();
        do_reset();
        in_valid = 1'b1; in_instr = 32'hFE000EE3; pc = 64'h100;
        tick();
        in_valid = 1'b0;
        tests++; if (a_out_valid !== 1'b1 || a_out_fmt !== 3'd3 || a_out_illegal !== 1'b0) begin
            fails++; $display("FAIL branch_fmt got v%b fmt %0d ill %b exp v1 fmt 3 ill 0", a_out_valid, a_out_fmt, a_out_illegal); end
        tests++; if (a_out_imm !== 32'hFFFFFFFC || a_out_target !== 32'h000000FC || a_out_pc !== 32'h100) begin
            fails++; $display("FAIL branch_imm got imm %0h tgt %0h pc %0h exp fffffffc fc 100", a_out_imm, a_out_target, a_out_pc); end
        tests++; if (b_out_imm !== 64'hFFFFFFFFFFFFFFFC || b_out_target !== 64'hFC) begin
            fails++; $display("FAIL branch_imm64 got imm %0h tgt %0h exp fffffffffffffffc fc", b_out_imm, b_out_target); end
        tick();
        tests++; if (a_out_valid !== 1'b0) begin fails++; $display("FAIL branch_drain got %b exp 0", a_out_valid); end
    endtask

    task automatic test_j_u();
        do_reset();
        in_valid = 1'b1; in_instr = 32'h800000EF; pc = 64'h0;
        tick();
        tests++; if (b_out_fmt !== 3'd5 || b_out_imm !== 64'hFFFFFFFFFFF00000 || b_out_target !== 64'hFFFFFFFFFFF00000) begin
            fails++; $display("FAIL jal64 got fmt %0d imm %0h tgt %0h exp 5 fffffffffff00000 fffffffffff00000",
                              b_out_fmt, b_out_imm, b_out_target); end
        in_instr = 32'h800002B7; pc = 64'h1000;
        tick();
        in_valid = 1'b0;
        tests++; if (b_out_fmt !== 3'd4 || b_out_imm !== 64'hFFFFFFFF80000000 || b_out_target !== 64'hFFFFFFFF80001000) begin
            fails++; $display("FAIL lui64 got fmt %0d imm %0h tgt %0h exp 4 ffffffff80000000 ffffffff80001000",
                              b_out_fmt, b_out_imm, b_out_target); end
        tests++; if (a_out_imm !== 32'h80000000 || a_out_target !== 32'h80001000) begin
            fails++; $display("FAIL lui32 got imm %0h tgt %0h exp 80000000 80001000", a_out_imm, a_out_target); end
        tick();
    endtask

    task automatic test_decode_edges();
        do_reset();
        in_valid = 1'b1; in_instr = 32'h3401D073; pc = 64'h200;
        tick();
        tests++; if (a_out_fmt !== 3'd6 || a_out_imm !== 32'd3 || a_out_illegal !== 1'b0) begin
            fails++; $display("FAIL csrrwi got fmt %0d imm %0h ill %b exp 6 3 0", a_out_fmt, a_out_imm, a_out_illegal); end
        in_instr = 32'h00000073;
        tick();
        tests++; if (a_out_fmt !== 3'd0 || a_out_imm !== 32'd0 || a_out_illegal !== 1'b0 || a_cnt_acc !== 16'd2) begin
            fails++; $display("FAIL ecall got fmt %0d imm %0h ill %b acc %0d exp 0 0 0 2", a_out_fmt, a_out_imm, a_out_illegal, a_cnt_acc); end
        in_instr = 32'h0010009B;
        tick();
        tests++; if (a_out_illegal !== 1'b1 || a_out_fmt !== 3'd0 || a_cnt_ill !== 16'd1) begin
            fails++; $display("FAIL addiw32 got ill %b fmt %0d cnt_ill %0d exp 1 0 1", a_out_illegal, a_out_fmt, a_cnt_ill); end
        tests++; if (b_out_illegal !== 1'b0 || b_out_fmt !== 3'd1 || b_out_imm !== 64'd1 || b_cnt_ill !== 16'd0) begin
            fails++; $display("FAIL addiw64 got ill %b fmt %0d imm %0h cnt_ill %0d exp 0 1 1 0", b_out_illegal, b_out_fmt, b_out_imm, b_cnt_ill); end
        in_instr = 32'h00000001;
        tick();
        in_valid = 1'b0;
        tests++; if (a_out_illegal !== 1'b1 || a_out_imm !== 32'd0 || a_cnt_acc !== 16'd4 || a_cnt_ill !== 16'd2) begin
            fails++; $display("FAIL low_bits got ill %b imm %0h acc %0d ill_cnt %0d exp 1 0 4 2", a_out_illegal, a_out_imm, a_cnt_acc, a_cnt_ill); end
        tests++; if (b_out_illegal !== 1'b1 || b_cnt_ill !== 16'd1) begin
            fails++; $display("FAIL low_bits64 got ill %b cnt_ill %0d exp 1 1", b_out_illegal, b_cnt_ill); end
        tick();
    endtask

    task automatic test_stall_back_to_back();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00500093; pc = 64'h10;
        tick();
        in_instr = 32'h00A00113; pc = 64'h14;
        for (int c = 0; c < 3; c++) begin
            tests++; if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_out_imm !== 32'd5 || a_out_pc !== 32'h10 || a_cnt_acc !== 16'd1) begin
                fails++; $display("FAIL stall_hold cyc %0d got rdy %b v %b imm %0h pc %0h acc %0d exp 0 1 5 10 1",
                                  c, a_in_ready, a_out_valid, a_out_imm, a_out_pc, a_cnt_acc); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        tests++; if (a_in_ready !== 1'b1) begin fails++; $display("FAIL stall_release got %b exp 1", a_in_ready); end
        tick();
        tests++; if (a_out_valid !== 1'b1 || a_out_imm !== 32'd10 || a_out_pc !== 32'h14) begin
            fails++; $display("FAIL b2b_first got v %b imm %0h pc %0h exp 1 a 14", a_out_valid, a_out_imm, a_out_pc); end
        in_instr = 32'h00F00193; pc = 64'h18;
        tick();
        in_valid = 1'b0;
        tests++; if (a_out_valid !== 1'b1 || a_out_imm !== 32'd15 || a_out_target !== 32'h27 || a_cnt_acc !== 16'd3) begin
            fails++; $display("FAIL b2b_second got v %b imm %0h tgt %0h acc %0d exp 1 f 27 3", a_out_valid, a_out_imm, a_out_target, a_cnt_acc); end
        tick();
        tests++; if (a_out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain got %b exp 0", a_out_valid); end
    endtask

    task automatic test_flush_and_reset();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00500093; pc = 64'h10;
        tick();
        out_ready = 1'b1; flush = 1'b1; in_instr = 32'h00A00113; pc = 64'h14;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        tests++; if (a_out_valid !== 1'b0 || a_cnt_acc !== 16'd1 || a_cnt_ill !== 16'd0) begin
            fails++; $display("FAIL flush got v %b acc %0d ill %0d exp 0 1 0", a_out_valid, a_cnt_acc, a_cnt_ill); end
        in_valid = 1'b1; in_instr = 32'h0000007F; pc = 64'h20;
        tick();
        in_instr = 32'h00A00113; pc = 64'h24;
        tick();
        rst = 1'b1; flush = 1'b1;
        #1;
        tests++; if (a_in_ready !== 1'b0) begin fails++; $display("FAIL rst_mid_ready got %b exp 0", a_in_ready); end
        tick();
        tests++; if (a_out_valid !== 1'b0 || a_out_imm !== 32'd0 || a_out_pc !== 32'd0 || a_out_target !== 32'd0 || a_cnt_acc !== 16'd0) begin
            fails++; $display("FAIL rst_mid got v %b imm %0h pc %0h tgt %0h acc %0d exp all 0",
                              a_out_valid, a_out_imm, a_out_pc, a_out_target, a_cnt_acc); end
        rst = 1'b0; flush = 1'b0; in_instr = 32'h00500093; pc = 64'h30;
        tick();
        in_valid = 1'b0;
        tests++; if (a_out_valid !== 1'b1 || a_out_pc !== 32'h30 || a_cnt_acc !== 16'd1) begin
            fails++; $display("FAIL rst_first_capture got v %b pc %0h acc %0d exp 1 30 1", a_out_valid, a_out_pc, a_cnt_acc); end
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        in_valid = 1'b1; in_instr = 32'h0000007F; pc = 64'h0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            tests++; if (s_cnt_acc !== 3'((i > 7) ? 7 : i) || s_cnt_ill !== 3'((i > 7) ? 7 : i)) begin
                fails++; $display("FAIL sat capture %0d got %0d/%0d exp %0d", i, s_cnt_acc, s_cnt_ill, (i > 7) ? 7 : i); end
        end
        in_valid = 1'b0;
        tests++; if (a_cnt_acc !== 16'd10 || a_cnt_ill !== 16'd10) begin
            fails++; $display("FAIL wide_cnt got %0d/%0d exp 10/10", a_cnt_acc, a_cnt_ill); end
        tick();
    endtask

    initial begin
        test_reset();
        test_branch();
        test_j_u();
        test_decode_edges();
        test_stall_back_to_back();
        test_flush_and_reset();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imm_decode_stage.md
# imm_decode_stage

Registered, parametrised immediate-decode stage sitting between the IF/ID pipeline register and the ID/EX control path. Accepts one 32-bit instruction plus PC per handshake, selects the immediate format from the opcode itself, produces the XLEN-wide sign-extended immediate and the PC-relative target, and flags non-decodable encodings. It supports stall via valid/ready, flush, RV32/RV64 widths, and saturating accept/illegal counters.

## Interface
- XLEN, 32: datapath width. Only 32 and 64 are legal; any other value is an elaboration error.
- CNT_W, 16: width of the statistics counters.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard the held entry and any same-cycle capture.
- in_valid  in  1  upstream holds a valid instruction.
- in_ready  out  1  stage can accept this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts this cycle.
- out_imm  out  XLEN  decoded immediate.
- out_fmt  out  3  format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm), 7 reserved and never driven.
- out_target  out  XLEN  out_pc + out_imm, modulo 2^XLEN.
- out_pc  out  XLEN  registered in_pc.
- out_illegal  out  1  encoding not decodable by this stage.
- cnt_accepted  out  CNT_W  saturating count of captured instructions.
- cnt_illegal  out  CNT_W  saturating count of captured illegal instructions.

## Operation
- Format select, using opcode = instr[6:0]:
  - 0000011 LOAD, 0010011 OP-IMM, 1100111 JALR, 0001111 FENCE -> I.
  - 0100011 -> S. 1100011 -> B. 0110111 LUI and 0010111 AUIPC -> U. 1101111 -> J.
  - 0110011 OP -> NONE, legal.
  - 1110011 SYSTEM: funct3 = 000 -> NONE; funct3[2] = 1 -> Z; otherwise -> I.
  - 0011011 OP-IMM-32 -> I when XLEN = 64; illegal when XLEN = 32.
  - Every other opcode, or instr[1:0] != 11 -> NONE with illegal = 1.
- Immediates. All sign bits come from instr[31] and are extended to XLEN.
  - I = instr[31:20].
  - S = {instr[31:25], instr[11:7]}.
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U = {instr[31:12], 12'b0}, sign-extended above bit 31 when XLEN = 64.
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - Z = instr[19:15] zero-extended.
  - NONE -> 0.
- Target: out_target = pc + imm, computed before the register. Overflow wraps and no carry is kept.
- Handshake:
  - in_ready = !rst && (!out_valid || out_ready).
  - Capture when in_valid && in_ready && !flush. All out_* fields load together.
  - Hold: while out_valid && !out_ready, all out_* fields stay stable.
  - out_valid next = capture ? 1 : (out_ready ? 0 : out_valid).
- Flush has priority. It forces out_valid = 0 next cycle and suppresses capture and counter updates. Data fields may keep their old values.
- Counters:
  - cnt_accepted increments by 1 on each capture.
  - cnt_illegal increments by 1 on each capture with illegal = 1.
  - Both saturate at 2^CNT_W - 1 and never wrap.

## Timing
- Latency is 1 cycle from capture edge to out_valid.
- Throughput is 1 instruction per cycle when out_ready is held high.
- in_ready is combinational from out_valid and out_ready. No other input-to-output combinational path exists.
- Reset: out_valid = 0, out_imm = 0, out_fmt = 0, out_target = 0, out_pc = 0, out_illegal = 0, cnt_accepted = 0, cnt_illegal = 0, in_ready = 0 while rst is high.
- Reset asserted mid-stream drops the held entry. The first capture is possible in the cycle after rst deasserts.
- Simultaneous pop and push (out_valid && out_ready && in_valid): the new entry loads and out_valid stays 1, with no bubble.
- Flush together with in_valid and in_ready: nothing captured, out_valid = 0 next cycle.
- Flush together with rst: reset wins, with the same end state.
- A counter at max with a further capture stays at max. cnt_illegal ≤ cnt_accepted always holds.

## Test plan
- **Branch:** XLEN=32, in_instr=0xFE000EE3 (beq, offset -4), in_pc=0x100 -> next cycle out_fmt=3, out_imm=0xFFFFFFFC, out_target=0x000000FC, out_illegal=0.
- **J and U formats:** XLEN=64.
  - JAL 0x800000EF at pc 0 -> out_fmt=5, out_imm=0xFFFFFFFFFFF00000, out_target=0xFFFFFFFFFFF00000.
  - LUI 0x800002B7 -> out_fmt=4, out_imm=0xFFFFFFFF80000000.
- **Decode edge cases:**
  - CSRRWI 0x3401D073 -> out_fmt=6, out_imm=3.
  - ECALL 0x00000073 -> out_fmt=0, out_imm=0, legal.
  - Opcode 0011011 at XLEN=32 -> illegal=1 and cnt_illegal increments.
  - Word 0x00000001 (instr[1:0] != 11) -> illegal=1.
- **Stall:** out_ready held low 3 cycles with in_valid high -> in_ready=0, out_* unchanged, cnt_accepted unchanged. Then out_ready=1 -> back-to-back transfers with no bubble.
- **Flush:** flush with a held entry and in_valid=1 -> out_valid=0 next cycle, counters unchanged. A reset pulse during streaming -> all outputs 0 and in_ready=0 during rst.
- **Saturation:** CNT_W=3, 10 captures of an illegal opcode -> cnt_accepted=7 and cnt_illegal=7, held at 7.
